// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock digit interface: sender FSM
// states and the active-low 7-segment encoding used by the lock display.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } sender_state_t;

  // Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_P     = 7'b0011000;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_bcd.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show blank.
module seg7_bcd
  import lock_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = bcd_to_seg(bcd_i);
  end

endmodule

// File: rtl/lock_code_sender.sv
// Plays a stored BCD code out to the lock one digit per valid/ready handshake,
// with optional idle gaps between digits and a registered 7-segment echo.
module lock_code_sender
  import lock_pkg::*;
#(
  parameter int                          NUM_DIGITS   = 6,
  parameter logic [4*NUM_DIGITS-1:0]     DEFAULT_CODE = 24'h211525,
  parameter int                          GAP_CYCLES   = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [4*NUM_DIGITS-1:0]        code_in,
  input  logic                           load,
  input  logic                           start,
  input  logic                           abort,
  output logic [3:0]                     digit_out,
  output logic                           digit_valid,
  input  logic                           digit_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           load_err,
  output logic [$clog2(NUM_DIGITS)-1:0]  digit_idx,
  output logic [6:0]                     hex_out,
  output sender_state_t                  state_dbg
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Handshake: a digit is accepted on any rising edge where digit_valid and
  // digit_ready are both high; digit_out/digit_valid stay put until then.

  sender_state_t             state_q;
  logic [4*NUM_DIGITS-1:0]   code_q;
  logic [IDX_W-1:0]          idx_q;
  logic [GAP_W-1:0]          gap_q;
  logic [3:0]                digit_q;
  logic                      valid_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;
  logic [6:0]                hex_q;

  logic [IDX_W-1:0]          sel_d;
  logic [3:0]                digit_d;
  logic [6:0]                seg_d;
  logic                      load_ok_d;
  logic                      handshake;

  // The only digit ever needed next is the first (leaving IDLE) or idx+1.
  always_comb begin
    sel_d = (state_q == ST_IDLE) ? '0 : idx_q + IDX_W'(1);
    digit_d = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_d == IDX_W'(i)) digit_d = code_q[4*(NUM_DIGITS-1-i) +: 4];
    end
    load_ok_d = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (code_in[4*i +: 4] > 4'd9) load_ok_d = 1'b0;
    end
  end

  seg7_bcd u_seg (
    .bcd_i (digit_d),
    .seg_o (seg_d)
  );

  assign handshake = valid_q & digit_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      code_q  <= DEFAULT_CODE;
      idx_q   <= '0;
      gap_q   <= '0;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hex_q   <= SEG_BLANK;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            if (load_ok_d) code_q <= code_in;
            else           err_q  <= 1'b1;
          end else if (start) begin
            state_q <= ST_SEND;
            idx_q   <= '0;
            digit_q <= digit_d;
            hex_q   <= seg_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (abort) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            hex_q   <= SEG_BLANK;
          end else if (handshake) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
              idx_q   <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hex_q   <= SEG_BLANK;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              digit_q <= digit_d;
              hex_q   <= seg_d;
              if (GAP_CYCLES > 0) begin
                state_q <= ST_GAP;
                valid_q <= 1'b0;
                gap_q   <= GAP_LOAD;
              end
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            hex_q   <= SEG_BLANK;
          end else if (gap_q == '0) begin
            state_q <= ST_SEND;
            valid_q <= 1'b1;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign digit_out   = digit_q;
  assign digit_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign load_err    = err_q;
  assign digit_idx   = idx_q;
  assign hex_out     = hex_q;
  assign state_dbg   = state_q;

endmodule

// File: doc/lock_code_sender.md
Name: lock_code_sender

Overview:
- Transmit side of the combination-lock digit interface. The lock consumes one BCD digit per clock step; this block stores a 6-digit BCD code and plays it out one digit at a time over a valid/ready handshake.
- Used to drive the lock automatically, for example from a test harness or a remote-unlock path.
- Shows the digit currently being sent on a 7-segment display, using the same active-low encoding the lock uses.

Parameters:
- NUM_DIGITS, 6, number of BCD digits in the code. Index counter width is clog2(NUM_DIGITS).
- DEFAULT_CODE, 24'h211525, code loaded at reset. Packed BCD, most-significant nibble is sent first.
- GAP_CYCLES, 2, idle cycles inserted between accepted digits. 0 means back-to-back.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- code_in  in  4*NUM_DIGITS  packed BCD code to load
- load  in  1  single-cycle load request; honoured only in IDLE
- start  in  1  single-cycle start request; honoured only in IDLE
- abort  in  1  cancels a transfer in progress
- digit_out  out  4  current BCD digit
- digit_valid  out  1  digit_out is valid
- digit_ready  in  1  consumer accepts the digit this cycle
- busy  out  1  high in SEND or GAP
- done  out  1  one-cycle pulse after the last digit is accepted
- load_err  out  1  one-cycle pulse when a load contains a nibble greater than 9
- digit_idx  out  clog2(NUM_DIGITS)  index of the digit being sent; 0 is the MS nibble
- hex_out  out  7  segments {a,b,c,d,e,f,g}, active-low
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 5 = 0100100
  - blank = 1111111

Behaviour:
- Reset values (synchronous, active-high, applied at the clock edge):
  - state = IDLE, code register = DEFAULT_CODE, digit_idx = 0.
  - digit_valid = 0, busy = 0, done = 0, load_err = 0, digit_out = 0, hex_out = blank.
- All outputs are registered.
- States:
  - IDLE: digit_valid = 0, hex_out blank.
    - load with all nibbles ≤ 9: code register <= code_in.
    - load with any nibble > 9: load_err pulses next cycle and the code is unchanged.
    - start with no load in the same cycle: go to SEND with digit_idx = 0.
    - load and start in the same cycle: load wins, start is ignored.
  - SEND: digit_valid = 1, digit_out = code[digit_idx], hex_out = seg(digit_out).
    - digit_out and digit_valid hold stable while digit_ready = 0; there is no timeout.
    - Handshake (digit_valid & digit_ready):
      - If digit_idx = NUM_DIGITS-1, go to DONE.
      - Otherwise digit_idx increments, and the next state is GAP (if GAP_CYCLES > 0) or SEND.
    - Latency: the first digit_valid appears 1 cycle after start. With GAP_CYCLES = 0, digits are sent on consecutive handshake cycles.
  - GAP: digit_valid = 0.
    - hex_out shows the next digit.
    - A down-counter loaded with GAP_CYCLES-1 runs; at 0 the block returns to SEND.
    - Each gap lasts exactly GAP_CYCLES cycles.
  - DONE: done = 1 for exactly one cycle, then IDLE. digit_idx is reset to 0.
- abort in SEND or GAP:
  - Next cycle: IDLE, digit_valid = 0, digit_idx = 0, no done pulse.
  - A handshake in the same cycle as abort is still counted as accepted, but abort wins the next-state decision.
- load or start outside IDLE: ignored.
- reset mid-transfer: IDLE, and the code reverts to DEFAULT_CODE.
- hex_out is driven blank for any code value > 9. This is unreachable after load checking, but the decoder's default branch is required.

Decomposition:
- Shared package lock_pkg:
  - State enum for sender_state_t (IDLE, SEND, GAP, DONE).
  - 7-segment constants: SEG_BLANK, plus the lock's existing letter constants for symmetry.
  - Function or constant table for BCD-to-segment encoding.
- One sub-module: seg7_bcd. A combinational BCD-to-segment decoder, shared with the lock top and reused here behind an output register.

Test Plan:
- Default code after reset, GAP_CYCLES = 2, digit_ready tied 1, then start:
  - digits 2,1,1,5,2,5 appear with 2 idle cycles between each.
  - hex_out on the first digit is 0010010.
  - done pulses once, 1 cycle after the digit 5 handshake; busy drops the same cycle as done.
- load 24'h907310, then start; digit_ready low for 3 cycles on digit 0 (value 9):
  - digit_out = 9 and digit_valid = 1 held for all 3 cycles.
  - Sequence continues 0,7,3,1,0.
- load 24'h21C525:
  - load_err pulses 1 cycle.
  - A following start sends 2,1,1,5,2,5, i.e. the code is unchanged.
- abort at digit_idx = 3 during SEND:
  - Next cycle: state IDLE, digit_valid = 0, digit_idx = 0, no done.
  - A fresh start restarts from digit 2.
- load and start in the same IDLE cycle with 24'h000000:
  - The code updates, busy stays 0, no digits are sent.
  - A subsequent start sends six 0s, each with hex_out = 0000001.
- reset asserted during GAP after a custom load:
  - Next cycle all outputs are at their reset values.
  - A following start sends DEFAULT_CODE (2,1,1,5,2,5).
